// File: rtl/data_mem_stage_if.sv
// Request/acknowledge data-memory port between the MEM stage and data memory.
interface data_mem_stage_if #(
   parameter int DATA_W = 64
);
   logic              mem_req;
   logic              mem_we;
   logic              mem_byte;
   logic [DATA_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_byte, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_byte, mem_addr, mem_wdata,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/data_mem_stage.sv
// LEGv8 MEM stage: EX/MEM register, data-memory handshake FSM and MEM/WB register.
// Optional MEM_TIMEOUT_EN aborts an unacknowledged access after TIMEOUT cycles.
module data_mem_stage #(
   parameter int DATA_W  = 64,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ex_valid,
   input  logic [DATA_W-1:0] ex_alu_result,
   input  logic [DATA_W-1:0] ex_store_data,
   input  logic              ex_mem_read,
   input  logic              ex_mem_write,
   input  logic              ex_byte,
   input  logic              ex_reg_write,
   input  logic              ex_mem_to_reg,
   input  logic [4:0]        ex_rd,
   output logic              stall,
   data_mem_stage_if.master  mem,
   output logic [DATA_W-1:0] alu_result_mem,
   output logic [4:0]        mem_rd,
   output logic              mem_reg_write,
   output logic              wb_valid,
   output logic              wb_reg_write,
   output logic [4:0]        wb_rd,
   output logic [DATA_W-1:0] wb_data,
   output logic [DATA_W-1:0] alu_result_wb,
   output logic              err_misalign
`ifdef MEM_TIMEOUT_EN
   ,
   output logic              err_timeout
`endif
);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t            state_q, state_d;
   logic              exmValid_q, exmRead_q, exmWrite_q, exmByte_q;
   logic              exmRegWrite_q, exmMemToReg_q;
   logic [DATA_W-1:0] exmAlu_q, exmStore_q;
   logic [4:0]        exmRd_q;
   logic              wbValid_q, wbValid_d, wbRegWrite_q, wbRegWrite_d;
   logic [4:0]        wbRd_q, wbRd_d;
   logic [DATA_W-1:0] wbData_q, wbData_d, wbAlu_q, wbAlu_d;
   logic              errMisalign_q, errMisalign_d;
   logic              timeoutHit, ackDone;
   logic              exStartsAccess, exmMisalign;
   logic [DATA_W-1:0] loadData;

   // Byte accesses never fault; doubleword accesses need addr[2:0] == 0.
   assign exStartsAccess = ex_valid & (ex_mem_read | ex_mem_write)
                         & (ex_byte | (ex_alu_result[2:0] == 3'b000));
   assign exmMisalign    = exmValid_q & (exmRead_q | exmWrite_q) & ~exmByte_q
                         & (exmAlu_q[2:0] != 3'b000);
   assign loadData       = exmByte_q ? {{(DATA_W-8){1'b0}}, mem.mem_rdata[7:0]}
                                     : mem.mem_rdata;
   assign ackDone        = mem.mem_req & mem.mem_ack;

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] toCnt_q, toCnt_d;
   logic             errTimeout_q, errTimeout_d;

   assign timeoutHit   = (state_q == ACCESS) && (toCnt_q == CNT_W'(TIMEOUT));
   assign toCnt_d      = stall ? toCnt_q + CNT_W'(1) : '0;
   assign errTimeout_d = errTimeout_q | timeoutHit;
   assign err_timeout  = errTimeout_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         toCnt_q      <= '0;
         errTimeout_q <= 1'b0;
      end else begin
         toCnt_q      <= toCnt_d;
         errTimeout_q <= errTimeout_d;
      end
   end
`else
   assign timeoutHit = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (exStartsAccess) state_d = ACCESS;
         ACCESS:  if (!stall) state_d = exStartsAccess ? ACCESS : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      stall         = 1'b0;
      mem.mem_req   = 1'b0;
      mem.mem_we    = 1'b0;
      mem.mem_byte  = exmByte_q;
      mem.mem_addr  = exmAlu_q;
      mem.mem_wdata = exmStore_q;
      if (state_q == ACCESS) begin
         mem.mem_req = ~timeoutHit;
         mem.mem_we  = ~timeoutHit & exmWrite_q & ~exmRead_q;
         stall       = ~timeoutHit & ~mem.mem_ack;
      end
   end

   // Every edge writes MEM/WB: a retiring instruction, or a bubble when stalled/aborted.
   always_comb begin
      wbValid_d     = 1'b0;
      wbRegWrite_d  = 1'b0;
      wbRd_d        = wbRd_q;
      wbData_d      = wbData_q;
      wbAlu_d       = wbAlu_q;
      errMisalign_d = errMisalign_q | ((state_q == IDLE) & exmMisalign);
      if (state_q == IDLE) begin
         if (exmValid_q && !exmMisalign) begin
            wbValid_d    = 1'b1;
            wbRegWrite_d = exmRegWrite_q;
            wbRd_d       = exmRd_q;
            wbData_d     = exmAlu_q;
            wbAlu_d      = exmAlu_q;
         end
      end else if (ackDone) begin
         wbValid_d    = 1'b1;
         wbRegWrite_d = exmRegWrite_q & exmRead_q;
         wbRd_d       = exmRd_q;
         wbData_d     = (exmRead_q | exmMemToReg_q) ? loadData : exmAlu_q;
         wbAlu_d      = exmAlu_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         exmValid_q    <= 1'b0;
         exmRead_q     <= 1'b0;
         exmWrite_q    <= 1'b0;
         exmByte_q     <= 1'b0;
         exmRegWrite_q <= 1'b0;
         exmMemToReg_q <= 1'b0;
         exmAlu_q      <= '0;
         exmStore_q    <= '0;
         exmRd_q       <= '0;
      end else if (!stall) begin
         exmValid_q    <= ex_valid;
         exmRead_q     <= ex_mem_read;
         exmWrite_q    <= ex_mem_write;
         exmByte_q     <= ex_byte;
         exmRegWrite_q <= ex_reg_write;
         exmMemToReg_q <= ex_mem_to_reg;
         exmAlu_q      <= ex_alu_result;
         exmStore_q    <= ex_store_data;
         exmRd_q       <= ex_rd;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wbValid_q     <= 1'b0;
         wbRegWrite_q  <= 1'b0;
         wbRd_q        <= '0;
         wbData_q      <= '0;
         wbAlu_q       <= '0;
         errMisalign_q <= 1'b0;
      end else begin
         wbValid_q     <= wbValid_d;
         wbRegWrite_q  <= wbRegWrite_d;
         wbRd_q        <= wbRd_d;
         wbData_q      <= wbData_d;
         wbAlu_q       <= wbAlu_d;
         errMisalign_q <= errMisalign_d;
      end
   end

   assign alu_result_mem = exmAlu_q;
   assign mem_rd         = exmRd_q;
   assign mem_reg_write  = exmValid_q & exmRegWrite_q;
   assign wb_valid       = wbValid_q;
   assign wb_reg_write   = wbRegWrite_q;
   assign wb_rd          = wbRd_q;
   assign wb_data        = wbData_q;
   assign alu_result_wb  = wbAlu_q;
   assign err_misalign   = errMisalign_q;

endmodule

// File: tb/tb_data_mem_stage.sv
// Scoreboard bench for data_mem_stage: driver pushes expected requests/retirements,
// a monitor pops and compares them as the DUT presents them.
module tb_data_mem_stage;
   localparam int DATA_W = 64;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              ex_valid = 1'b0;
   logic [DATA_W-1:0] ex_alu_result = '0;
   logic [DATA_W-1:0] ex_store_data = '0;
   logic              ex_mem_read = 1'b0, ex_mem_write = 1'b0, ex_byte = 1'b0;
   logic              ex_reg_write = 1'b0, ex_mem_to_reg = 1'b0;
   logic [4:0]        ex_rd = '0;
   logic              stall;
   logic [DATA_W-1:0] alu_result_mem, alu_result_wb, wb_data;
   logic [4:0]        mem_rd, wb_rd;
   logic              mem_reg_write, wb_valid, wb_reg_write, err_misalign;

   data_mem_stage_if #(.DATA_W(DATA_W)) memIf ();

   data_mem_stage #(.DATA_W(DATA_W), .TIMEOUT(15)) dut (
      .clk            (clk),
      .reset          (reset),
      .ex_valid       (ex_valid),
      .ex_alu_result  (ex_alu_result),
      .ex_store_data  (ex_store_data),
      .ex_mem_read    (ex_mem_read),
      .ex_mem_write   (ex_mem_write),
      .ex_byte        (ex_byte),
      .ex_reg_write   (ex_reg_write),
      .ex_mem_to_reg  (ex_mem_to_reg),
      .ex_rd          (ex_rd),
      .stall          (stall),
      .mem            (memIf),
      .alu_result_mem (alu_result_mem),
      .mem_rd         (mem_rd),
      .mem_reg_write  (mem_reg_write),
      .wb_valid       (wb_valid),
      .wb_reg_write   (wb_reg_write),
      .wb_rd          (wb_rd),
      .wb_data        (wb_data),
      .alu_result_wb  (alu_result_wb),
      .err_misalign   (err_misalign)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  rd;
      logic [63:0] data;
      logic        regWrite;
   } retire_t;

   typedef struct {
      logic [63:0] addr;
      logic        we;
      logic        isByte;
      logic [63:0] wdata;
   } req_t;

   retire_t     retireQ[$];
   req_t        reqQ[$];
   int          totalChecks = 0;
   int          badChecks = 0;
   int          stallCycles = 0;
   int          reqCycles = 0;
   int          ackDelay = 0;
   logic [63:0] rdataVal = '0;

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      totalChecks++;
      if (actual !== expected) begin
         badChecks++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic rd_, input logic wr_, input logic byt,
                                input logic regw, input logic m2r,
                                input logic [63:0] alu, input logic [63:0] store,
                                input logic [4:0] rdn, input logic [63:0] expData);
      logic isMem, misaligned, isStore;
      int   n;
      isMem      = rd_ | wr_;
      isStore    = wr_ & ~rd_;
      misaligned = isMem & ~byt & (alu[2:0] != 3'b000);
      ex_valid      = 1'b1;
      ex_mem_read   = rd_;
      ex_mem_write  = wr_;
      ex_byte       = byt;
      ex_reg_write  = regw;
      ex_mem_to_reg = m2r;
      ex_alu_result = alu;
      ex_store_data = store;
      ex_rd         = rdn;
      if (isMem && !misaligned)
         reqQ.push_back('{addr: alu, we: isStore, isByte: byt, wdata: store});
      if (!misaligned)
         retireQ.push_back('{rd: rdn, data: expData, regWrite: regw & ~isStore});
      n = 0;
      do begin
         @(negedge clk);
         #2;
         n++;
      end while (stall && n < 40);
      if (stall) begin
         totalChecks++;
         badChecks++;
         $display("[TB] FAIL issueTimeout: stall still %b after %0d cycles", stall, n);
      end
      @(posedge clk);
      #1;
      ex_valid = 1'b0;
   endtask

   task automatic applyIdle(input int n);
      ex_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Memory responder: acknowledges after ackDelay wait cycles.
   initial begin
      int waitCnt;
      waitCnt = 0;
      memIf.mem_ack   = 1'b0;
      memIf.mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (memIf.mem_req === 1'b1) begin
            if (waitCnt >= ackDelay) begin
               memIf.mem_ack   = 1'b1;
               memIf.mem_rdata = rdataVal;
               waitCnt = 0;
            end else begin
               memIf.mem_ack = 1'b0;
               waitCnt++;
            end
         end else begin
            memIf.mem_ack = 1'b0;
            waitCnt = 0;
         end
      end
   end

   initial begin
      bit      prevStall;
      retire_t r;
      prevStall = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         if (reset !== 1'b1) begin
            prevStall = 1'b0;
         end else begin
            if (prevStall) checkOutput("bubbleAfterStall", wb_valid, 0);
            if (stall) stallCycles++;
            if (memIf.mem_req === 1'b1) begin
               reqCycles++;
               if (reqQ.size() == 0) begin
                  totalChecks++;
                  badChecks++;
                  $display("[TB] FAIL unexpectedReq: addr %h we %b with none expected",
                           memIf.mem_addr, memIf.mem_we);
               end else begin
                  checkOutput("reqAddr", memIf.mem_addr, reqQ[0].addr);
                  checkOutput("reqWe", memIf.mem_we, reqQ[0].we);
                  checkOutput("reqByte", memIf.mem_byte, reqQ[0].isByte);
                  checkOutput("reqWdata", memIf.mem_wdata, reqQ[0].wdata);
                  if (memIf.mem_ack === 1'b1) void'(reqQ.pop_front());
               end
            end
            if (wb_valid === 1'b1) begin
               if (retireQ.size() == 0) begin
                  totalChecks++;
                  badChecks++;
                  $display("[TB] FAIL unexpectedRetire: rd %0d data %h with none expected",
                           wb_rd, wb_data);
               end else begin
                  r = retireQ.pop_front();
                  checkOutput("wbRd", wb_rd, r.rd);
                  checkOutput("wbData", wb_data, r.data);
                  checkOutput("wbRegWrite", wb_reg_write, r.regWrite);
               end
            end
            prevStall = stall;
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      #2 reset = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checkOutput("rstStall", stall, 0);
      checkOutput("rstMemReq", memIf.mem_req, 0);
      checkOutput("rstWbValid", wb_valid, 0);
      checkOutput("rstWbRegWrite", wb_reg_write, 0);
      checkOutput("rstWbData", wb_data, 0);
      checkOutput("rstWbRd", wb_rd, 0);
      checkOutput("rstAluMem", alu_result_mem, 0);
      checkOutput("rstAluWb", alu_result_wb, 0);
      checkOutput("rstMemRegWrite", mem_reg_write, 0);
      checkOutput("rstErrMisalign", err_misalign, 0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] ALU op");
      stallCycles = 0;
      applyStimulus(0, 0, 0, 1, 0, 64'h2AA, 64'h0, 5'd3, 64'h2AA);
      checkOutput("aluResultMem", alu_result_mem, 64'h2AA);
      checkOutput("memRd", mem_rd, 3);
      checkOutput("memRegWrite", mem_reg_write, 1);
      applyIdle(3);
      checkOutput("aluResultWb", alu_result_wb, 64'h2AA);
      checkOutput("aluStallCycles", stallCycles, 0);

      $display("[TB] LDUR with wait states");
      ackDelay = 2;
      rdataVal = 64'hDEADBEEF;
      stallCycles = 0;
      reqCycles = 0;
      applyStimulus(1, 0, 0, 1, 1, 64'h10, 64'h0, 5'd7, 64'hDEADBEEF);
      applyIdle(4);
      checkOutput("ldurStallCycles", stallCycles, 2);
      checkOutput("ldurReqCycles", reqCycles, 3);

      $display("[TB] LDURB zero-wait");
      ackDelay = 0;
      rdataVal = 64'hFFFF_FF80;
      stallCycles = 0;
      reqCycles = 0;
      applyStimulus(1, 0, 1, 1, 1, 64'h13, 64'h0, 5'd9, 64'h80);
      applyIdle(3);
      checkOutput("ldurbStallCycles", stallCycles, 0);
      checkOutput("ldurbReqCycles", reqCycles, 1);

      $display("[TB] misaligned STUR");
      reqCycles = 0;
      applyStimulus(0, 1, 0, 0, 0, 64'h0C, 64'h55, 5'd0, 64'h0C);
      applyIdle(2);
      checkOutput("misReqCycles", reqCycles, 0);
      checkOutput("misErr", err_misalign, 1);
      checkOutput("misWbRegWrite", wb_reg_write, 0);
      applyIdle(3);
      checkOutput("misErrSticky", err_misalign, 1);

      $display("[TB] back-to-back STUR then LDUR");
      ackDelay = 1;
      rdataVal = 64'h1234_5678;
      stallCycles = 0;
      reqCycles = 0;
      applyStimulus(0, 1, 0, 0, 0, 64'h8, 64'h1234_5678, 5'd0, 64'h8);
      applyStimulus(1, 0, 0, 1, 1, 64'h8, 64'h0, 5'd5, 64'h1234_5678);
      applyIdle(4);
      checkOutput("b2bReqCycles", reqCycles, 4);
      checkOutput("b2bStallCycles", stallCycles, 2);

      $display("[TB] reset during access");
      ackDelay = 50;
      ex_valid      = 1'b1;
      ex_mem_read   = 1'b1;
      ex_mem_write  = 1'b0;
      ex_byte       = 1'b0;
      ex_reg_write  = 1'b1;
      ex_mem_to_reg = 1'b1;
      ex_alu_result = 64'h20;
      ex_rd         = 5'd6;
      reqQ.push_back('{addr: 64'h20, we: 1'b0, isByte: 1'b0, wdata: ex_store_data});
      @(posedge clk);
      #1;
      ex_valid = 1'b0;
      @(negedge clk);
      #2;
      checkOutput("preRstMemReq", memIf.mem_req, 1);
      checkOutput("preRstStall", stall, 1);
      #1 reset = 1'b0;
      #1;
      checkOutput("midRstMemReq", memIf.mem_req, 0);
      checkOutput("midRstStall", stall, 0);
      checkOutput("midRstErr", err_misalign, 0);
      reqQ.delete();
      retireQ.delete();
      ackDelay = 0;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(0, 0, 0, 1, 0, 64'h55, 64'h0, 5'd4, 64'h55);
      applyIdle(3);

      checkOutput("reqQDrained", reqQ.size(), 0);
      checkOutput("retireQDrained", retireQ.size(), 0);
      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end
endmodule

// File: doc/data_mem_stage.md
Name: data_mem_stage

Overview:
- MEM stage of the pipelined LEGv8 CPU; sits directly downstream of the execute datapath.
- Holds the EX/MEM pipeline register and drives a request/acknowledge data-memory port (LDUR/STUR/LDURB/STURB).
- Stalls upstream stages while an access is outstanding and produces the MEM/WB register.
- Exports alu_result_mem and alu_result_wb to the execute-stage forwarding muxes.

Parameters:
- DATA_W, 64, datapath and address width.
- TIMEOUT, 15, max cycles waiting for mem_ack; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- ex_valid  in  1  EX result valid this cycle.
- ex_alu_result  in  DATA_W  ALU result / effective address.
- ex_store_data  in  DATA_W  store data (forwarded ReadData2).
- ex_mem_read, ex_mem_write, ex_byte  in  1 each  load, store, byte-size access.
- ex_reg_write, ex_mem_to_reg  in  1 each  WB controls.
- ex_rd  in  5  destination register.
- stall  out  1  freeze PC/IF/ID/EX registers.
- mem_req, mem_we, mem_byte  out  1 each  memory request, write, byte size.
- mem_addr, mem_wdata  out  DATA_W  request address/data.
- mem_ack  in  1  access complete this cycle.
- mem_rdata  in  DATA_W  load data, valid when mem_ack.
- alu_result_mem  out  DATA_W  EX/MEM ALU result (forwarding).
- mem_rd  out  5;  mem_reg_write  out  1  EX/MEM dest info (hazard unit).
- wb_valid, wb_reg_write  out  1 each;  wb_rd  out  5.
- wb_data  out  DATA_W  load data or ALU result.
- alu_result_wb  out  DATA_W  MEM/WB ALU result (forwarding).
- err_misalign  out  1  sticky misaligned-access flag.

Behaviour:
- Reset (reset=0, async): state=IDLE; EX/MEM and MEM/WB valid bits, reg_write bits, all data/rd outputs, err_misalign = 0.
- EX/MEM capture: on each edge with stall=0, load all ex_* fields; with stall=1, hold.
- FSM IDLE: EX/MEM entry valid and non-memory (or invalid) -> stays IDLE; at the next edge, MEM/WB gets wb_data=alu_result and the controls. Total latency 1 cycle, never stalls.
- IDLE -> ACCESS: at the edge where a valid memory op (read or write) is captured into EX/MEM.
- ACCESS outputs: mem_req=1; mem_addr/mem_wdata/mem_we/mem_byte driven from EX/MEM and held stable until ack.
  - stall = ACCESS & ~mem_ack (combinational); zero-wait memory causes no bubble.
- ACCESS, mem_ack=1: MEM/WB captures at this edge.
  - Load: wb_data = mem_rdata; byte loads are zero-extended from mem_rdata[7:0].
  - Store: wb_reg_write=0.
  - Next state is ACCESS if the newly captured EX entry is a memory op, else IDLE.
- ACCESS, mem_ack=0: each stalled edge loads a bubble into MEM/WB (wb_valid=0, wb_reg_write=0).
- Misaligned: doubleword access with addr[2:0]!=0 issues no mem_req and completes in 1 cycle as a bubble (wb_reg_write=0); err_misalign set, sticky until reset. Byte accesses are never misaligned.
- Store data: mem_wdata = full 64-bit store data; for bytes, memory uses only [7:0].
- mem_ack while mem_req=0: ignored.
- Reset mid-access: request dropped immediately; state IDLE.
- ex_mem_read and ex_mem_write both 1 is illegal; treated as a load.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments each unacknowledged cycle.
  - When it reaches TIMEOUT, the access aborts: mem_req drops, the instruction retires as a bubble, and output err_timeout (1 bit, sticky until reset) sets.
  - stall drops in that same cycle.
- Undefined: no counter, no err_timeout port; stall waits indefinitely for mem_ack.

Test Plan:
- ALU op, ex_alu_result=0x2AA, ex_rd=3, reg_write=1 -> next cycle alu_result_mem=0x2AA; following cycle wb_data=0x2AA, wb_rd=3; stall never 1.
- LDUR addr 0x10, mem_ack after 3 cycles with rdata 0xDEADBEEF -> mem_req=1, mem_addr=0x10 held stable 3 cycles; stall=1 for 2 cycles; wb_data=0xDEADBEEF; 2 bubbles on wb_valid.
- LDURB addr 0x13, immediate ack, rdata 0xFFFF_FF80 -> wb_data=0x80 (zero-extended); stall never 1.
- STUR addr 0x0C, data 0x55 -> no mem_req, err_misalign=1 and stays 1; wb_reg_write=0.
- Back-to-back STUR 0x8 then LDUR 0x8, one wait cycle each -> two distinct requests in order, mem_we 1 then 0; load retires after the store.
- reset=0 during ACCESS -> mem_req=0 and stall=0 asynchronously. With MEM_TIMEOUT_EN and no ack -> abort after 15 cycles, err_timeout=1.
